// File: rtl/control_unit.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory, writeback,
// the multiplier handshake and the exception entry/return path; drives every datapath enable.
module control_unit #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mult_done,
  output logic       PC_write,
  output logic       MEM_write,
  output logic       IR_write,
  output logic       A_write,
  output logic       B_write,
  output logic       ALUout_write,
  output logic       HI_write,
  output logic       LO_write,
  output logic       EPC_write,
  output logic       Reg_write,
  output logic [1:0] PcSource,
  output logic [1:0] IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       mult_start,
  output logic       ExceptCode
);

  localparam int            CW   = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_MULT = 6'h18,
                         F_RTE = 6'h13;
  localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;

  typedef enum logic [4:0] {
    FETCH, DECODE, BRADDR, R_EX, R_WB, I_EX, I_WB, ADDR, MEM_RD, LW_WB, MEM_WR,
    BEQ, JMP, MULT_GO, MULT_WAIT, RTE, EXC0, EXC1, EXC2, EXC3, EXC4
  } state_t;

  typedef struct packed {
    logic       pcw, memw, irw, aw, bw, aluow, hiw, low, epcw, regw;
    logic [1:0] pcsrc, iord;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       regdst, m2r, mstart, exc;
  } ctl_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exc_q, exc_d;
  ctl_t          c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    c       = '0;
    case (state_q)
      FETCH: begin
        c.srcb = 2'b01; c.aluop = ALU_ADD; c.aluow = 1'b1;
        if (cnt_q == LAST) begin
          c.irw   = 1'b1;
          state_d = DECODE;
        end else cnt_d = cnt_q + CW'(1);
      end
      DECODE: begin
        c.pcw = 1'b1; c.aw = 1'b1; c.bw = 1'b1;
        state_d = BRADDR;
      end
      BRADDR: begin
        c.srcb = 2'b11; c.aluop = ALU_ADD; c.aluow = 1'b1;
        state_d = EXC0;
        exc_d   = 1'b0;
        case (opcode)
          OP_R: case (funct)
            F_ADD, F_SUB, F_AND: state_d = R_EX;
            F_MULT:              state_d = MULT_GO;
            F_RTE:               state_d = RTE;
            default:             state_d = EXC0;
          endcase
          OP_ADDI:      state_d = I_EX;
          OP_LW, OP_SW: state_d = ADDR;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JMP;
          default:      state_d = EXC0;
        endcase
      end
      R_EX: begin
        c.srca = 1'b1; c.aluow = 1'b1;
        c.aluop = (funct == F_SUB) ? ALU_SUB : (funct == F_AND) ? ALU_AND : ALU_ADD;
        // and cannot overflow, so only add/sub divert to the exception path
        if (overflow && funct != F_AND) begin
          state_d = EXC0;
          exc_d   = 1'b1;
        end else state_d = R_WB;
      end
      R_WB: begin
        c.regw = 1'b1; c.regdst = 1'b1;
        state_d = FETCH;
      end
      I_EX: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = ALU_ADD; c.aluow = 1'b1;
        if (overflow) begin
          state_d = EXC0;
          exc_d   = 1'b1;
        end else state_d = I_WB;
      end
      I_WB: begin
        c.regw = 1'b1;
        state_d = FETCH;
      end
      ADDR: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = ALU_ADD; c.aluow = 1'b1;
        state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        c.iord = 2'b01;
        if (cnt_q == LAST) state_d = LW_WB;
        else cnt_d = cnt_q + CW'(1);
      end
      LW_WB: begin
        c.regw = 1'b1; c.m2r = 1'b1;
        state_d = FETCH;
      end
      MEM_WR: begin
        c.memw = 1'b1; c.iord = 2'b01;
        state_d = FETCH;
      end
      BEQ: begin
        c.srca = 1'b1; c.aluop = ALU_SUB; c.pcw = zero;
        state_d = FETCH;
      end
      JMP: begin
        c.pcw = 1'b1; c.pcsrc = 2'b01;
        state_d = FETCH;
      end
      MULT_GO: begin
        c.mstart = 1'b1;
        state_d  = MULT_WAIT;
      end
      MULT_WAIT: begin
        c.hiw = mult_done; c.low = mult_done;
        if (mult_done) state_d = FETCH;
      end
      RTE: begin
        c.pcw = 1'b1; c.pcsrc = 2'b11;
        state_d = FETCH;
      end
      EXC0: begin
        c.srcb = 2'b01; c.aluop = ALU_SUB; c.aluow = 1'b1; c.exc = exc_q;
        state_d = EXC1;
      end
      EXC1: begin
        c.pcw = 1'b1; c.exc = exc_q;
        state_d = EXC2;
      end
      EXC2: begin
        c.epcw = 1'b1; c.exc = exc_q;
        state_d = EXC3;
      end
      EXC3: begin
        c.iord = 2'b10; c.exc = exc_q;
        if (cnt_q == LAST) state_d = EXC4;
        else cnt_d = cnt_q + CW'(1);
      end
      EXC4: begin
        c.pcw = 1'b1; c.pcsrc = 2'b10; c.exc = exc_q;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // every wait state starts its count from zero
    if (state_d != state_q) cnt_d = '0;
  end

  assign {PC_write, MEM_write, IR_write, A_write, B_write, ALUout_write, HI_write, LO_write,
          EPC_write, Reg_write, PcSource, IorD, ALUSrcA, ALUSrcB, ALUop, RegDst, MemToReg,
          mult_start, ExceptCode} = reset ? c : '0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model expands each instruction
// into its expected per-cycle control words; one negedge process compares them.
module tb_control_unit;
  localparam int LAT = 2;

  typedef struct packed {
    logic       pcw, memw, irw, aw, bw, aluow, hiw, low, epcw, regw;
    logic [1:0] pcsrc, iord;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       regdst, m2r, mstart, exc;
  } outs_t;

  typedef struct {
    outs_t e;
    bit    last;
    int    lr, lm, ls, lh, le;
  } ent_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0, mult_done = 1'b0;
  logic PC_write, MEM_write, IR_write, A_write, B_write, ALUout_write, HI_write, LO_write;
  logic EPC_write, Reg_write, ALUSrcA, RegDst, MemToReg, mult_start, ExceptCode;
  logic [1:0] PcSource, IorD, ALUSrcB;
  logic [2:0] ALUop;

  control_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mult_done(mult_done), .PC_write(PC_write), .MEM_write(MEM_write),
    .IR_write(IR_write), .A_write(A_write), .B_write(B_write), .ALUout_write(ALUout_write),
    .HI_write(HI_write), .LO_write(LO_write), .EPC_write(EPC_write), .Reg_write(Reg_write),
    .PcSource(PcSource), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .RegDst(RegDst), .MemToReg(MemToReg), .mult_start(mult_start), .ExceptCode(ExceptCode)
  );

  always #5 clk = ~clk;

  outs_t dut_o;
  assign dut_o = {PC_write, MEM_write, IR_write, A_write, B_write, ALUout_write, HI_write,
                  LO_write, EPC_write, Reg_write, PcSource, IorD, ALUSrcA, ALUSrcB, ALUop,
                  RegDst, MemToReg, mult_start, ExceptCode};

  ent_t  q[$];
  outs_t seq[$];
  logic  mdq[$];
  int    n_vec = 0, n_err = 0;
  int    c_regw = 0, c_memw = 0, c_mst = 0, c_hilo = 0, c_epc = 0;
  ent_t  cur;

  function automatic void chk(string nm, int got, int ex);
    if (ex >= 0) begin
      n_vec++;
      if (got != ex) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", nm, got, ex);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      n_vec++;
      if (dut_o !== cur.e) begin
        n_err++;
        $display("FAIL outputs @%0t: got %h want %h", $time, dut_o, cur.e);
      end
      c_regw = c_regw + int'(dut_o.regw);
      c_memw = c_memw + int'(dut_o.memw);
      c_mst  = c_mst  + int'(dut_o.mstart);
      c_hilo = c_hilo + int'(dut_o.hiw & dut_o.low);
      c_epc  = c_epc  + int'(dut_o.epcw);
      if (cur.last) begin
        chk("Reg_write count", c_regw, cur.lr);
        chk("MEM_write count", c_memw, cur.lm);
        chk("mult_start count", c_mst, cur.ls);
        chk("HI/LO write count", c_hilo, cur.lh);
        chk("EPC_write count", c_epc, cur.le);
        c_regw = 0; c_memw = 0; c_mst = 0; c_hilo = 0; c_epc = 0;
      end
    end
  end

  function automatic void push(outs_t w, logic [31:0] mdm);
    int k = seq.size();
    seq.push_back(w);
    mdq.push_back(k < 32 ? mdm[k] : 1'b0);
  endfunction

  function automatic void exc_seq(logic code, logic [31:0] mdm);
    outs_t w;
    w = '0; w.srcb = 2'b01; w.aluop = 3'b010; w.aluow = 1'b1; w.exc = code; push(w, mdm);
    w = '0; w.pcw = 1'b1; w.exc = code; push(w, mdm);
    w = '0; w.epcw = 1'b1; w.exc = code; push(w, mdm);
    for (int i = 0; i < LAT; i++) begin
      w = '0; w.iord = 2'b10; w.exc = code; push(w, mdm);
    end
    w = '0; w.pcw = 1'b1; w.pcsrc = 2'b10; w.exc = code; push(w, mdm);
  endfunction

  // Expand one instruction into the control words it must produce, cycle by cycle
  function automatic void build(logic [5:0] op, logic [5:0] fn, logic ovf, logic z,
                                logic [31:0] mdm);
    outs_t w;
    bit r_alu = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
    seq.delete(); mdq.delete();
    for (int i = 0; i < LAT; i++) begin
      w = '0; w.srcb = 2'b01; w.aluop = 3'b001; w.aluow = 1'b1; w.irw = (i == LAT - 1);
      push(w, mdm);
    end
    w = '0; w.pcw = 1'b1; w.aw = 1'b1; w.bw = 1'b1; push(w, mdm);
    w = '0; w.srcb = 2'b11; w.aluop = 3'b001; w.aluow = 1'b1; push(w, mdm);
    if (r_alu) begin
      w = '0; w.srca = 1'b1; w.aluow = 1'b1;
      w.aluop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      push(w, mdm);
      if (ovf && fn != 6'h24) exc_seq(1'b1, mdm);
      else begin w = '0; w.regw = 1'b1; w.regdst = 1'b1; push(w, mdm); end
    end else if (op == 6'h08) begin
      w = '0; w.srca = 1'b1; w.srcb = 2'b10; w.aluop = 3'b001; w.aluow = 1'b1; push(w, mdm);
      if (ovf) exc_seq(1'b1, mdm);
      else begin w = '0; w.regw = 1'b1; push(w, mdm); end
    end else if (op == 6'h23 || op == 6'h2B) begin
      w = '0; w.srca = 1'b1; w.srcb = 2'b10; w.aluop = 3'b001; w.aluow = 1'b1; push(w, mdm);
      if (op == 6'h23) begin
        for (int i = 0; i < LAT; i++) begin w = '0; w.iord = 2'b01; push(w, mdm); end
        w = '0; w.regw = 1'b1; w.m2r = 1'b1; push(w, mdm);
      end else begin
        w = '0; w.memw = 1'b1; w.iord = 2'b01; push(w, mdm);
      end
    end else if (op == 6'h04) begin
      w = '0; w.srca = 1'b1; w.aluop = 3'b010; w.pcw = z; push(w, mdm);
    end else if (op == 6'h02) begin
      w = '0; w.pcw = 1'b1; w.pcsrc = 2'b01; push(w, mdm);
    end else if (op == 6'h00 && fn == 6'h18) begin
      w = '0; w.mstart = 1'b1; push(w, mdm);
      for (int g = 0; g < 24; g++) begin
        int k = seq.size();
        w = '0;
        if (k < 32 && mdm[k]) begin
          w.hiw = 1'b1; w.low = 1'b1; push(w, mdm);
          break;
        end
        push(w, mdm);
      end
    end else if (op == 6'h00 && fn == 6'h13) begin
      w = '0; w.pcw = 1'b1; w.pcsrc = 2'b11; push(w, mdm);
    end else exc_seq(1'b0, mdm);
  endfunction

  task automatic step(outs_t e, bit last, int lr, int lm, int ls, int lh, int le);
    ent_t x;
    x.e = e; x.last = last; x.lr = lr; x.lm = lm; x.ls = ls; x.lh = lh; x.le = le;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic run(logic [5:0] op, logic [5:0] fn, logic ovf, logic z, logic [31:0] mdm,
                     int lr, int lm, int ls, int lh, int le);
    build(op, fn, ovf, z, mdm);
    opcode = op; funct = fn; overflow = ovf; zero = z;
    for (int i = 0; i < seq.size(); i++) begin
      mult_done = mdq[i];
      step(seq[i], i == seq.size() - 1, lr, lm, ls, lh, le);
    end
    mult_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    outs_t w;
    @(posedge clk); #1;
    // held in reset: everything low
    step('0, 1'b0, -1, -1, -1, -1, -1);
    step('0, 1'b0, -1, -1, -1, -1, -1);
    reset = 1'b1;
    w = '0; w.srcb = 2'b01; w.aluop = 3'b001; w.aluow = 1'b1;
    step(w, 1'b0, -1, -1, -1, -1, -1);
    reset = 1'b0;                             // abort mid-FETCH
    step('0, 1'b0, -1, -1, -1, -1, -1);
    reset = 1'b1;
    //   op     fn     ovf   z     mult_done mask                     regw memw mst hilo epc
    run(6'h00, 6'h20, 1'b0, 1'b0, 32'h1,                              1,   0,  0,  0,   0);
    run(6'h00, 6'h20, 1'b1, 1'b0, 32'h0,                              0,   0,  0,  0,   1);
    run(6'h00, 6'h22, 1'b0, 1'b0, 32'h0,                              1,   0,  0,  0,   0);
    run(6'h00, 6'h24, 1'b1, 1'b0, 32'h0,                              1,   0,  0,  0,   0);
    run(6'h08, 6'h00, 1'b0, 1'b0, 32'h0,                              1,   0,  0,  0,   0);
    run(6'h08, 6'h00, 1'b1, 1'b0, 32'h0,                              0,   0,  0,  0,   1);
    run(6'h3F, 6'h00, 1'b0, 1'b0, 32'h0,                              0,   0,  0,  0,   1);
    run(6'h00, 6'h3F, 1'b0, 1'b0, 32'h0,                              0,   0,  0,  0,   1);
    run(6'h23, 6'h00, 1'b0, 1'b0, 32'h0,                              1,   0,  0,  0,   0);
    run(6'h2B, 6'h00, 1'b0, 1'b0, 32'h0,                              0,   1,  0,  0,   0);
    run(6'h04, 6'h00, 1'b0, 1'b1, 32'h0,                              0,   0,  0,  0,   0);
    run(6'h04, 6'h00, 1'b0, 1'b0, 32'h0,                              0,   0,  0,  0,   0);
    run(6'h02, 6'h00, 1'b0, 1'b0, 32'h0,                              0,   0,  0,  0,   0);
    run(6'h00, 6'h13, 1'b0, 1'b0, 32'h0,                              0,   0,  0,  0,   0);
    // stray done in FETCH, a done coinciding with mult_start, then the real one 5 cycles later
    run(6'h00, 6'h18, 1'b0, 1'b0, (32'h1 << 0) | (32'h1 << 4) | (32'h1 << 9),
                                                                       0,   0,  1,  1,   0);
    run(6'h00, 6'h20, 1'b0, 1'b0, 32'h0,                              1,   0,  0,  0,   0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
